// File: rtl/ahb_apb_multi_bridge_pkg.sv
// Shared types for the AHB-Lite to multi-slave APB3 bridge: FSM states, AHB codes, index width helper.
// Pure declarations; no logic, no latency, no backpressure.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // A single slave still needs a 1-bit index field.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ahb_apb_multi_bridge_if.sv
// AHB-Lite slave side plus NUM_SLV-wide APB3 master side of the bridge.
// Bundle only; the slave modport is the bridge view, master is the surrounding fabric.
interface ahb_apb_multi_bridge_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                      HSEL;
    logic [ADDR_W-1:0]         HADDR;
    logic [1:0]                HTRANS;
    logic                      HWRITE;
    logic [DATA_W-1:0]         HWDATA;
    logic                      HREADY;
    logic [DATA_W-1:0]         HRDATA;
    logic                      HREADYOUT;
    logic [1:0]                HRESP;

    logic [ADDR_W-1:0]         PADDR;
    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PWDATA;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  PRDATA, PREADY, PSLVERR,
        output HRDATA, HREADYOUT, HRESP,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output PRDATA, PREADY, PSLVERR,
        input  HRDATA, HREADYOUT, HRESP,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

endinterface

// File: rtl/ahb_apb_multi_bridge_apb_slave_mux.sv
// Selects one APB slave's PRDATA/PREADY/PSLVERR by index; unmapped index returns all zeros.
// Combinational, zero latency; no backpressure of its own.
module apb_slave_mux #(
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int IDX_W   = 2
) (
    input  logic [IDX_W-1:0]          idx,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic [DATA_W-1:0]         sel_prdata,
    output logic                      sel_pready,
    output logic                      sel_pslverr
);

    always_comb begin
        sel_prdata  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (int'(idx) == i) begin
                sel_prdata  = prdata[i*DATA_W +: DATA_W];
                sel_pready  = pready[i];
                sel_pslverr = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/ahb_apb_multi_bridge.sv
// AHB-Lite slave to NUM_SLV-way APB3 master bridge with decode error and PREADY timeout.
// Latency: 3 wait states for a zero-wait APB slave, +1 per PREADY-low cycle; stalls AHB via HREADYOUT.
module ahb_apb_multi_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input logic                  HCLK,
    input logic                  HRESETN,
    ahb_apb_multi_bridge_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_SLV);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               in_range;
    logic               timed_out;
    logic               hreadyout_nxt;
    logic [1:0]         hresp_nxt;
    logic [NUM_SLV-1:0] psel_nxt;
    logic               penable_nxt;
    logic [DATA_W-1:0]  sel_prdata;
    logic               sel_pready;
    logic               sel_pslverr;
    logic               unused_htrans0;

    // NONSEQ and SEQ both have HTRANS[1] set; the low bit carries no information here.
    assign unused_htrans0 = bus.HTRANS[0];
    assign accept         = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign in_range       = int'(idx) < NUM_SLV;
    assign timed_out      = (TIMEOUT != 0) && (cnt == TO_VAL);

    apb_slave_mux #(
        .DATA_W  (DATA_W),
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_mux (
        .idx         (idx),
        .prdata      (bus.PRDATA),
        .pready      (bus.PREADY),
        .pslverr     (bus.PSLVERR),
        .sel_prdata  (sel_prdata),
        .sel_pready  (sel_pready),
        .sel_pslverr (sel_pslverr)
    );

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR2: state_nxt = accept ? ST_WAIT : ST_IDLE;
            ST_WAIT:   state_nxt = in_range ? ST_SETUP : ST_ERR1;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_pready) begin
                    state_nxt = sel_pslverr ? ST_ERR1 : ST_DONE;
                end else if (timed_out) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1:   state_nxt = ST_ERR2;
            default:   state_nxt = ST_IDLE;
        endcase

        hreadyout_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE) || (state_nxt == ST_ERR2);
        hresp_nxt     = ((state_nxt == ST_ERR1) || (state_nxt == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        penable_nxt   = (state_nxt == ST_ACCESS);
        psel_nxt      = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            psel_nxt[i] = ((state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS)) && (int'(idx) == i);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            idx           <= '0;
            cnt           <= '0;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= HRESP_OKAY;
            bus.HRDATA    <= '0;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
        end else begin
            bus.HREADYOUT <= hreadyout_nxt;
            bus.HRESP     <= hresp_nxt;
            bus.PSEL      <= psel_nxt;
            bus.PENABLE   <= penable_nxt;

            if (state_nxt == ST_WAIT) begin
                bus.PADDR  <= bus.HADDR;
                bus.PWRITE <= bus.HWRITE;
                idx        <= bus.HADDR[SEL_LSB +: IDX_W];
            end

            if (state == ST_WAIT) begin
                bus.PWDATA <= bus.HWDATA;
            end

            if (state == ST_SETUP) begin
                cnt <= '0;
            end else if (state == ST_ACCESS) begin
                cnt <= cnt + 1'b1;
            end

            if ((state == ST_ACCESS) && sel_pready && !sel_pslverr && !bus.PWRITE) begin
                bus.HRDATA <= sel_prdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb_apb_multi_bridge.sv
// Bench for ahb_apb_multi_bridge: directed table, corner-case sequences and randomized traffic vs a cycle-count model.
// Instance A: 4 slaves, TIMEOUT=8. Instance B: 3 slaves, no timeout, used for the unmapped-slot case.
module tb_ahb_apb_multi_bridge;
    import ahb_apb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NA   = 4;
    localparam int NB   = 3;
    localparam int TO_A = 8;

    logic HCLK    = 1'b0;
    logic HRESETN = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_apb_multi_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NA)) ifa ();
    ahb_apb_multi_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NB)) ifb ();

    ahb_apb_multi_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NA), .SEL_LSB(12), .TIMEOUT(TO_A))
        dut_a (.HCLK(HCLK), .HRESETN(HRESETN), .bus(ifa));
    ahb_apb_multi_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NB), .SEL_LSB(12), .TIMEOUT(0))
        dut_b (.HCLK(HCLK), .HRESETN(HRESETN), .bus(ifb));

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          wt;
        logic        err;
        logic [31:0] rdata;
        int          e_low;
        int          e_acc;
        logic [1:0]  e_resp;
        logic [31:0] e_hrdata;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    int          r_low, r_acc;
    logic        r_timeout, r_multi, r_pwrite;
    logic [1:0]  r_resp_end, r_resp_pre;
    logic [31:0] r_hrdata, r_paddr, r_pwdata;
    logic [3:0]  r_psel_or;
    logic [31:0] m_hrdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Entered between a negedge and posedge with HREADYOUT high; returns at the negedge of the final data-phase cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int wt, input logic err, input logic [31:0] rdata);
        int sl;
        int acc;
        int low;
        sl  = int'(addr[13:12]);
        acc = 0;
        low = 0;
        ifa.HSEL = 1'b1; ifa.HTRANS = HTRANS_NONSEQ; ifa.HADDR = addr; ifa.HWRITE = wr; ifa.HREADY = 1'b1;
        @(posedge HCLK); #1;
        ifa.HSEL = 1'b0; ifa.HTRANS = HTRANS_IDLE; ifa.HWDATA = wdata;
        r_psel_or = '0; r_multi = 1'b0; r_timeout = 1'b1; r_resp_pre = HRESP_OKAY;
        r_paddr = '0; r_pwrite = 1'b0; r_pwdata = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge HCLK);
            ifa.HREADY = ifa.HREADYOUT;
            if ($countones(ifa.PSEL) > 1) r_multi = 1'b1;
            if (ifa.PSEL != '0 && r_psel_or == '0) begin
                r_paddr = ifa.PADDR; r_pwrite = ifa.PWRITE; r_pwdata = ifa.PWDATA;
            end
            r_psel_or = r_psel_or | ifa.PSEL;
            ifa.PREADY = '0; ifa.PSLVERR = '0;
            ifa.PRDATA = {NA{~rdata}};
            ifa.PRDATA[sl*DW +: DW] = rdata;
            if (ifa.PSEL[sl] && ifa.PENABLE) begin
                acc++;
                if (acc > wt) begin
                    ifa.PREADY[sl]  = 1'b1;
                    ifa.PSLVERR[sl] = err;
                end
            end
            if (ifa.HREADYOUT) begin
                r_resp_end = ifa.HRESP; r_hrdata = ifa.HRDATA; r_timeout = 1'b0;
                break;
            end
            low++;
            r_resp_pre = ifa.HRESP;
        end
        r_low = low;
        r_acc = acc;
    endtask

    task automatic check_x(input string tag, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int e_low, input int e_acc, input logic [1:0] e_resp, input logic [31:0] e_hrdata);
        chk({tag, "_done"},   r_timeout, 0);
        chk({tag, "_low"},    r_low, e_low);
        chk({tag, "_acc"},    r_acc, e_acc);
        chk({tag, "_hresp"},  r_resp_end, e_resp);
        chk({tag, "_hresp_wait"}, r_resp_pre, e_resp);
        chk({tag, "_hrdata"}, r_hrdata, e_hrdata);
        chk({tag, "_psel"},   r_psel_or, 4'b0001 << addr[13:12]);
        chk({tag, "_multi"},  r_multi, 0);
        chk({tag, "_paddr"},  r_paddr, addr);
        chk({tag, "_pwrite"}, r_pwrite, wr);
        if (wr) chk({tag, "_pwdata"}, r_pwdata, wdata);
    endtask

    // One non-accepted AHB cycle; the bridge must stay zero-wait OKAY with no APB select.
    task automatic idle_cyc(input string tag, input logic hsel, input logic [1:0] tr, input logic hrdy);
        ifa.HSEL = hsel; ifa.HTRANS = tr; ifa.HADDR = $urandom; ifa.HREADY = hrdy;
        @(posedge HCLK); #1;
        ifa.HSEL = 1'b0; ifa.HTRANS = HTRANS_IDLE; ifa.HREADY = 1'b1;
        @(negedge HCLK);
        chk({tag, "_hreadyout"}, ifa.HREADYOUT, 1);
        chk({tag, "_hresp"}, ifa.HRESP, HRESP_OKAY);
        chk({tag, "_psel"}, ifa.PSEL, 0);
    endtask

    vec_t vt [6];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  s2;
        logic        wr, err, hs, hr, found, e_err;
        logic [1:0]  tr, e_resp;
        logic [31:0] addr, wd, rd;
        int          wt, e_acc, e_low, low;
        logic [2:0]  pselb;

        vt[0] = '{32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 0,   1'b0, 32'h0,         3,  1, HRESP_OKAY,  32'h0};
        vt[1] = '{32'h0000_1000, 1'b0, 32'h0,         4,   1'b0, 32'h1234_5678, 7,  5, HRESP_OKAY,  32'h1234_5678};
        vt[2] = '{32'h0000_3000, 1'b0, 32'h0,         0,   1'b1, 32'hCAFE_F00D, 4,  1, HRESP_ERROR, 32'h1234_5678};
        vt[3] = '{32'h0000_3008, 1'b0, 32'h0,         100, 1'b0, 32'hAAAA_5555, 12, 9, HRESP_ERROR, 32'h1234_5678};
        vt[4] = '{32'h0000_0010, 1'b0, 32'h0,         8,   1'b0, 32'h0BAD_CAFE, 11, 9, HRESP_OKAY,  32'h0BAD_CAFE};
        vt[5] = '{32'h0000_1FFC, 1'b1, 32'h55AA_55AA, 2,   1'b1, 32'h0,         6,  3, HRESP_ERROR, 32'h0BAD_CAFE};

        ifa.HSEL = 0; ifa.HADDR = 0; ifa.HTRANS = HTRANS_IDLE; ifa.HWRITE = 0; ifa.HWDATA = 0; ifa.HREADY = 1;
        ifa.PRDATA = '0; ifa.PREADY = '0; ifa.PSLVERR = '0;
        ifb.HSEL = 0; ifb.HADDR = 0; ifb.HTRANS = HTRANS_IDLE; ifb.HWRITE = 0; ifb.HWDATA = 0; ifb.HREADY = 1;
        ifb.PRDATA = '0; ifb.PREADY = '0; ifb.PSLVERR = '0;

        #12;
        chk("rst_hreadyout", ifa.HREADYOUT, 1);
        chk("rst_hresp",     ifa.HRESP, 0);
        chk("rst_hrdata",    ifa.HRDATA, 0);
        chk("rst_psel",      ifa.PSEL, 0);
        chk("rst_penable",   ifa.PENABLE, 0);
        chk("rst_pwrite",    ifa.PWRITE, 0);
        chk("rst_paddr",     ifa.PADDR, 0);
        chk("rst_pwdata",    ifa.PWDATA, 0);
        chk("rst_b_hreadyout", ifb.HREADYOUT, 1);
        @(negedge HCLK);
        HRESETN = 1'b1;

        foreach (vt[i]) begin
            xfer(vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].wt, vt[i].err, vt[i].rdata);
            check_x($sformatf("vec%0d", i), vt[i].addr, vt[i].wr, vt[i].wdata,
                    vt[i].e_low, vt[i].e_acc, vt[i].e_resp, vt[i].e_hrdata);
            idle_cyc($sformatf("vec%0d_gap", i), 1'b1, HTRANS_IDLE, 1'b1);
        end
        m_hrdata = 32'h0BAD_CAFE;

        // Abandoned slave raising PREADY after the timeout must not disturb anything.
        xfer(32'h0000_2100, 1'b0, 32'h0, 100, 1'b0, 32'h7777_7777);
        check_x("tmo", 32'h0000_2100, 1'b0, 32'h0, 12, 9, HRESP_ERROR, m_hrdata);
        for (int k = 0; k < 2; k++) begin
            ifa.PREADY[2] = 1'b1; ifa.PRDATA[2*DW +: DW] = 32'h7777_7777;
            @(posedge HCLK); @(negedge HCLK);
            chk("late_ready_hreadyout", ifa.HREADYOUT, 1);
            chk("late_ready_psel", ifa.PSEL, 0);
            chk("late_ready_hrdata", ifa.HRDATA, m_hrdata);
        end
        ifa.PREADY = '0;

        // Back-to-back: second address phase overlaps the DONE cycle of the first.
        xfer(32'h0000_0040, 1'b1, 32'h1111_0000, 0, 1'b0, 32'h0);
        check_x("b2b_a", 32'h0000_0040, 1'b1, 32'h1111_0000, 3, 1, HRESP_OKAY, m_hrdata);
        xfer(32'h0000_1044, 1'b1, 32'h2222_0001, 0, 1'b0, 32'h0);
        check_x("b2b_b", 32'h0000_1044, 1'b1, 32'h2222_0001, 3, 1, HRESP_OKAY, m_hrdata);
        idle_cyc("b2b_idle", 1'b1, HTRANS_IDLE, 1'b1);
        idle_cyc("b2b_busy", 1'b1, HTRANS_BUSY, 1'b1);
        xfer(32'h0000_0048, 1'b1, 32'h3333_0002, 0, 1'b0, 32'h0);
        check_x("b2b_c", 32'h0000_0048, 1'b1, 32'h3333_0002, 3, 1, HRESP_OKAY, m_hrdata);
        idle_cyc("nohready", 1'b1, HTRANS_NONSEQ, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                hs = 1'(($urandom_range(0, 1)));
                tr = 2'($urandom_range(0, 3));
                hr = 1'(($urandom_range(0, 1)));
                if (hs && tr[1]) hr = 1'b0;
                idle_cyc("rnd_gap", hs, tr, hr);
            end
            s2   = 2'($urandom_range(0, 3));
            addr = $urandom;
            addr[13:12] = s2;
            wr   = 1'(($urandom_range(0, 1)));
            wt   = $urandom_range(0, 11);
            err  = ($urandom_range(0, 3) == 0);
            wd   = $urandom;
            rd   = $urandom;
            if (wt <= TO_A) begin
                e_acc = wt + 1;
                e_err = err;
            end else begin
                e_acc = TO_A + 1;
                e_err = 1'b1;
            end
            e_low  = 2 + e_acc + (e_err ? 1 : 0);
            e_resp = e_err ? HRESP_ERROR : HRESP_OKAY;
            if (!e_err && !wr) m_hrdata = rd;
            xfer(addr, wr, wd, wt, err, rd);
            check_x($sformatf("rnd%0d", n), addr, wr, wd, e_low, e_acc, e_resp, m_hrdata);
        end

        // Unmapped slot on the 3-slave instance: decode error, no APB select ever.
        @(negedge HCLK);
        ifb.HSEL = 1'b1; ifb.HTRANS = HTRANS_NONSEQ; ifb.HADDR = 32'h0000_3000; ifb.HWRITE = 1'b0; ifb.HREADY = 1'b1;
        ifb.PREADY = '1;
        @(posedge HCLK); #1;
        ifb.HSEL = 1'b0; ifb.HTRANS = HTRANS_IDLE;
        low = 0; pselb = '0; found = 1'b0; e_resp = HRESP_OKAY; r_resp_end = HRESP_OKAY;
        for (int c = 0; c < 10; c++) begin
            @(negedge HCLK);
            pselb = pselb | ifb.PSEL;
            ifb.HREADY = ifb.HREADYOUT;
            if (ifb.HREADYOUT) begin
                r_resp_end = ifb.HRESP; found = 1'b1;
                break;
            end
            low++;
            e_resp = ifb.HRESP;
        end
        chk("dec_done", found, 1);
        chk("dec_low", low, 2);
        chk("dec_psel", pselb, 0);
        chk("dec_hresp_err1", e_resp, HRESP_ERROR);
        chk("dec_hresp_err2", r_resp_end, HRESP_ERROR);
        chk("dec_hrdata", ifb.HRDATA, 0);
        ifb.PREADY = '0;

        // Asynchronous reset in the middle of an APB access.
        ifa.HSEL = 1'b1; ifa.HTRANS = HTRANS_NONSEQ; ifa.HADDR = 32'h0000_2010; ifa.HWRITE = 1'b0; ifa.HREADY = 1'b1;
        @(posedge HCLK); #1;
        ifa.HSEL = 1'b0; ifa.HTRANS = HTRANS_IDLE;
        found = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge HCLK);
            if (ifa.PENABLE) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_mid_reach_access", found, 1);
        #2 HRESETN = 1'b0;
        #1;
        chk("rst_mid_psel", ifa.PSEL, 0);
        chk("rst_mid_penable", ifa.PENABLE, 0);
        chk("rst_mid_hreadyout", ifa.HREADYOUT, 1);
        chk("rst_mid_hresp", ifa.HRESP, HRESP_OKAY);
        chk("rst_mid_hrdata", ifa.HRDATA, 0);
        @(negedge HCLK);
        HRESETN = 1'b1;
        xfer(32'h0000_1200, 1'b0, 32'h0, 1, 1'b0, 32'h5A5A_0F0F);
        check_x("post_rst", 32'h0000_1200, 1'b0, 32'h0, 4, 2, HRESP_OKAY, 32'h5A5A_0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
